// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths and architecturally named register indices.
// Imported by the register file, the decoder and the writeback mux.
package cpu_pkg;

    localparam int          CPU_DATA_W   = 32;
    localparam int          CPU_ADDR_W   = 5;
    localparam int          REG_ZERO     = 0;
    localparam int          REG_SP       = 29;
    localparam int          REG_RA       = 31;
    localparam int unsigned CPU_SP_RESET = 32'd128;

endpackage : cpu_pkg

// File: rtl/reg_file.sv
// 32 x 32 general-purpose register file: two combinational read ports with optional
// write-through forwarding, one write port, hard-wired zero register, SP reset value.
module reg_file
    import cpu_pkg::*;
#(
    parameter int          DATA_W   = CPU_DATA_W,
    parameter int          ADDR_W   = CPU_ADDR_W,
    parameter int          SP_IDX   = REG_SP,
    parameter int unsigned SP_RESET = CPU_SP_RESET,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              reg_write_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic              wr_en_s;
    logic [DATA_W-1:0] rs_data_s;
    logic [DATA_W-1:0] rt_data_s;

    // Qualified write strobe; gated by reset so forwarding cannot leak pending data during reset.
    always_comb begin
        wr_en_s = 1'b0;
        if (rst_i && reg_write_i && (rd_addr_i != ZERO_IDX)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Storage array: async clear (SP gets its reset value), one write per rising edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
            end
        end else if (wr_en_s) begin
            regs_r[rd_addr_i] <= rd_data_i;
        end
    end

    // Read port 1: zero register, then same-cycle forwarding, then stored value.
    always_comb begin
        rs_data_s = '0;
        if (rs_addr_i == ZERO_IDX) begin
            rs_data_s = '0;
        end else if (BYPASS && wr_en_s && (rd_addr_i == rs_addr_i)) begin
            rs_data_s = rd_data_i;
        end else begin
            rs_data_s = regs_r[rs_addr_i];
        end
    end

    // Read port 2: same selection as port 1, evaluated independently.
    always_comb begin
        rt_data_s = '0;
        if (rt_addr_i == ZERO_IDX) begin
            rt_data_s = '0;
        end else if (BYPASS && wr_en_s && (rd_addr_i == rt_addr_i)) begin
            rt_data_s = rd_data_i;
        end else begin
            rt_data_s = regs_r[rt_addr_i];
        end
    end

    assign rs_data_o = rs_data_s;
    assign rt_data_o = rt_data_s;

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; one instance with forwarding, one without,
// both driven by the same stimulus.
module tb_reg_file;

    logic        clk;
    logic        rst_i;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        reg_write;
    logic [31:0] rs_b, rt_b, rs_nb, rt_nb;

    int n_cmp = 0;
    int n_err = 0;

    reg_file #(.BYPASS(1'b1)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
        .rd_addr_i(rd_addr), .rd_data_i(rd_data), .reg_write_i(reg_write),
        .rs_data_o(rs_b), .rt_data_o(rt_b)
    );

    reg_file #(.BYPASS(1'b0)) dut_nb (
        .clk_i(clk), .rst_i(rst_i), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
        .rd_addr_i(rd_addr), .rd_data_i(rd_data), .reg_write_i(reg_write),
        .rs_data_o(rs_nb), .rt_data_o(rt_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;

        // Reset held; a write request is presented and must be ignored.
        rst_i     = 1'b0;
        rs_addr   = 5'd0;
        rt_addr   = 5'd0;
        rd_addr   = 5'd4;
        rd_data   = 32'hFFFF_FFFF;
        reg_write = 1'b1;
        #2;
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            exp_rs = (i == 29) ? 32'd128 : 32'd0;
            exp_rt = ((31 - i) == 29) ? 32'd128 : 32'd0;
            chk($sformatf("rst_rs_b[%0d]", i), rs_b, exp_rs);
            chk($sformatf("rst_rs_nb[%0d]", i), rs_nb, exp_rs);
            chk($sformatf("rst_rt_b[%0d]", 31 - i), rt_b, exp_rt);
        end

        // Release reset, re-read: contents unchanged.
        reg_write = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            #1;
            exp_rs = (i == 29) ? 32'd128 : 32'd0;
            chk($sformatf("post_rst_b[%0d]", i), rs_b, exp_rs);
            chk($sformatf("post_rst_nb[%0d]", i), rs_nb, exp_rs);
        end

        // Basic write to r5.
        rd_addr = 5'd5; rd_data = 32'hDEAD_BEEF; reg_write = 1'b1;
        rs_addr = 5'd5; rt_addr = 5'd6;
        #1;
        chk("wr5_pre_b", rs_b, 32'hDEAD_BEEF);
        chk("wr5_pre_nb", rs_nb, 32'h0);
        tick();
        reg_write = 1'b0;
        #1;
        chk("wr5_rs_b", rs_b, 32'hDEAD_BEEF);
        chk("wr5_rs_nb", rs_nb, 32'hDEAD_BEEF);
        chk("wr5_rt6_b", rt_b, 32'h0);
        chk("wr5_rt6_nb", rt_nb, 32'h0);

        // Writes to r0 are discarded.
        rd_addr = 5'd0; rd_data = 32'hFFFF_FFFF; reg_write = 1'b1;
        rs_addr = 5'd0; rt_addr = 5'd0;
        #1;
        chk("r0_pre_rs_b", rs_b, 32'h0);
        chk("r0_pre_rt_b", rt_b, 32'h0);
        chk("r0_pre_rs_nb", rs_nb, 32'h0);
        tick();
        chk("r0_post_rs_b", rs_b, 32'h0);
        chk("r0_post_rt_b", rt_b, 32'h0);
        chk("r0_post_rt_nb", rt_nb, 32'h0);
        reg_write = 1'b0;

        // Forwarding on both ports at once versus stored value.
        rd_addr = 5'd7; rd_data = 32'h0000_0010; reg_write = 1'b1;
        rs_addr = 5'd7; rt_addr = 5'd7;
        #1;
        chk("byp_rs_b", rs_b, 32'h10);
        chk("byp_rt_b", rt_b, 32'h10);
        chk("nobyp_rs_pre", rs_nb, 32'h0);
        chk("nobyp_rt_pre", rt_nb, 32'h0);
        tick();
        reg_write = 1'b0;
        #1;
        chk("byp_rs_post", rs_b, 32'h10);
        chk("nobyp_rs_post", rs_nb, 32'h10);
        chk("nobyp_rt_post", rt_nb, 32'h10);

        // Write enable gating on r3.
        rd_addr = 5'd3; rd_data = 32'h0000_1234; reg_write = 1'b0;
        rs_addr = 5'd3; rt_addr = 5'd3;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("gate_b[%0d]", c), rs_b, 32'h0);
            chk($sformatf("gate_nb[%0d]", c), rs_nb, 32'h0);
        end
        reg_write = 1'b1;
        #1;
        chk("gate_en_pre_b", rs_b, 32'h1234);
        chk("gate_en_pre_nb", rt_nb, 32'h0);
        tick();
        reg_write = 1'b0;
        #1;
        chk("gate_en_b", rs_b, 32'h1234);
        chk("gate_en_nb", rs_nb, 32'h1234);

        // SP is writable; then an async reset lands mid-cycle with a write pending.
        rd_addr = 5'd29; rd_data = 32'hA5A5_A5A5; reg_write = 1'b1;
        tick();
        reg_write = 1'b0;
        rs_addr = 5'd29; rt_addr = 5'd5;
        #1;
        chk("sp_wr_b", rs_b, 32'hA5A5_A5A5);
        chk("sp_wr_nb", rs_nb, 32'hA5A5_A5A5);
        chk("r5_keep", rt_nb, 32'hDEAD_BEEF);
        @(negedge clk);
        #2;
        rd_addr = 5'd29; rd_data = 32'h0000_0005; reg_write = 1'b1;
        rst_i = 1'b0;
        #1;
        chk("arst_sp_b", rs_b, 32'd128);
        chk("arst_sp_nb", rs_nb, 32'd128);
        chk("arst_r5_b", rt_b, 32'h0);
        chk("arst_r5_nb", rt_nb, 32'h0);
        rs_addr = 5'd3; rt_addr = 5'd7;
        #1;
        chk("arst_r3", rs_b, 32'h0);
        chk("arst_r7", rt_nb, 32'h0);
        rs_addr = 5'd29;
        tick();
        chk("arst_hold_sp_b", rs_b, 32'd128);
        chk("arst_hold_sp_nb", rs_nb, 32'd128);

        // First edge after release performs a normal write.
        rd_data = 32'h0000_0077;
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        chk("rel_pre_nb", rs_nb, 32'd128);
        tick();
        reg_write = 1'b0;
        #1;
        chk("rel_wr_b", rs_b, 32'h77);
        chk("rel_wr_nb", rs_nb, 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_reg_file

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle datapath.
- Sits directly upstream of the ALU.
  - Read port 1 drives the ALU's src1.
  - Read port 2 drives the src2 mux (register vs. sign-extended immediate).
- Written once per clock from the writeback mux (ALU result / memory data).
- Register 0 reads as constant zero. The stack-pointer register has a non-zero reset value.

Parameters:
- DATA_W, 32, register and port data width
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- SP_IDX, 29, index of the stack-pointer register
- SP_RESET, 128, reset value loaded into register SP_IDX
- BYPASS, 1, 1 = write-through forwarding on the read ports; 0 = read returns the old stored value

Ports:
- clk_i  in  1  clock; all writes occur on the rising edge
- rst_i  in  1  asynchronous reset, active-low
- rs_addr_i  in  ADDR_W  read port 1 index
- rt_addr_i  in  ADDR_W  read port 2 index
- rd_addr_i  in  ADDR_W  write index
- rd_data_i  in  DATA_W  write data
- reg_write_i  in  1  write enable
- rs_data_o  out  DATA_W  read port 1 data (to ALU src1)
- rt_data_o  out  DATA_W  read port 2 data (to src2 mux / store data)

Behaviour:
- Reset:
  - rst_i low, asynchronously: every register clears to 0, except register SP_IDX, which loads SP_RESET.
  - Reset is held as long as rst_i is low. Writes are ignored during reset.
  - Outputs reflect the reset contents combinationally (rs_data_o = rt_data_o = 0 for non-SP indices).
- Write:
  - Condition: reg_write_i = 1 and rd_addr_i != 0 at the rising edge of clk_i.
  - Effect: regs[rd_addr_i] <= rd_data_i. Latency is one edge.
  - A write to index 0 is discarded. Register 0 always reads 0.
- Read:
  - Combinational, zero latency from the address inputs.
  - Address 0 returns 0 regardless of any write activity.
- Bypass:
  - BYPASS = 1: if reg_write_i = 1, rd_addr_i != 0 and rd_addr_i equals a read address, that read port returns rd_data_i in the same cycle.
  - BYPASS = 0: the read port returns the stored value until the edge.
  - Bypass applies to each read port independently. Both ports may hit simultaneously.
- Same address on both ports: identical data on both outputs.
- Reset asserted mid-cycle while a write is pending: reset wins and the write is lost.
  - Release of rst_i is synchronised externally.
  - The first edge after release performs a normal write.
- SP register: readable and writable like any other register. SP_RESET applies only at reset.
- No X propagation:
  - All storage is initialised by reset.
  - Out-of-range addresses cannot occur, since depth = 2**ADDR_W.

Decomposition:
- Shared package (cpu_pkg) holds:
  - DATA_W and ADDR_W constants
  - named register indices: REG_ZERO = 0, REG_SP = 29, REG_RA = 31
  - SP_RESET default
- The decoder and writeback mux import the same package.
- No sub-module. The block is one storage array, plus a read mux with bypass compare per port.

Test Plan:
- Reset check: hold rst_i = 0, sweep all 32 read addresses.
  - Expect 0 everywhere except index 29 = 128.
  - Release reset and re-read: values unchanged.
- Basic write/read: write 0xDEADBEEF to r5 with reg_write_i = 1.
  - After the edge, rs_addr_i = 5 gives rs_data_o = 0xDEADBEEF.
  - rt_addr_i = 6 gives 0.
- Zero register: write 0xFFFFFFFF to r0.
  - rs_data_o and rt_data_o at address 0 stay 0, both before and after the edge.
- Bypass: BYPASS = 1, write 0x00000010 to r7 with rs_addr_i = rt_addr_i = 7.
  - Both outputs show 0x10 in the same cycle, before the edge.
  - Repeat with BYPASS = 0: outputs show the old value until the edge, then 0x10.
- Enable gating: rd_addr_i = 3, rd_data_i = 0x1234, reg_write_i = 0 for 3 cycles.
  - r3 stays 0. Assert reg_write_i for one edge: r3 = 0x1234.
- Async reset mid-operation: write 0xA5A5A5A5 to r29.
  - Drop rst_i between clock edges: r29 immediately reads 128 and other registers read 0, without waiting for a clock edge.
